// File: rtl/fp_mul_sequencer.sv
// Multi-cycle IEEE-754 multiply sequencer: classify, shift-add multiply,
// normalise and round-to-nearest-even, with denormals flushed to zero.
module fp_mul_sequencer #(
    parameter int EXPONENT_BITS  = 8,
    parameter int FRACTION_BITS  = 23,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_BITS+FRACTION_BITS:0]   a,
    input  logic [EXPONENT_BITS+FRACTION_BITS:0]   b,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXPONENT_BITS+FRACTION_BITS:0]   result,
    output logic                                   flag_invalid,
    output logic                                   flag_overflow,
    output logic                                   flag_underflow,
    output logic                                   flag_inexact,
    output logic                                   busy
);
    localparam int E    = EXPONENT_BITS;
    localparam int F    = FRACTION_BITS;
    localparam int W    = 1 + E + F;
    localparam int M    = F + 1;
    localparam int K    = BITS_PER_CYCLE;
    localparam int N    = M / K;
    localparam int CW   = $clog2(N + 1);
    localparam int XW   = E + 2;
    localparam int BIAS = 2 ** (E - 1) - 1;

    localparam logic [W-1:0] QNAN =
        {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'(2 ** E - 1);
    localparam logic signed [XW-1:0] EXP_MIN = '0;

    typedef enum logic [2:0] {IDLE, CHECK, MULT, NORM, DONE} state_t;

    state_t state, state_next;

    logic [W-1:0]           a_r, b_r;
    logic                   sign_r;
    logic [M-1:0]           mant_a;
    logic [2*M-1:0]         prod;
    logic signed [XW-1:0]   exp_sum;
    logic [CW-1:0]          count;

    // Operand classification (exponent zero covers both zero and denormal)
    logic [E-1:0] ea, eb;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;

    assign ea      = a_r[W-2:F];
    assign eb      = b_r[W-2:F];
    assign a_nan   = (&ea) && (|a_r[F-1:0]);
    assign b_nan   = (&eb) && (|b_r[F-1:0]);
    assign a_inf   = (&ea) && !(|a_r[F-1:0]);
    assign b_inf   = (&eb) && !(|b_r[F-1:0]);
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // One shift-add step: add multiplicand times the low multiplier bits
    // into the upper half, then shift the whole product right.
    logic [M+K-1:0] upper;
    logic [2*M-1:0] prod_step;

    assign upper = {{K{1'b0}}, prod[2*M-1:M]}
                 + ({{K{1'b0}}, mant_a} * {{M{1'b0}}, prod[K-1:0]});
    assign prod_step = {upper, prod[M-1:K]};

    // Normalise to [1,2) and round to nearest even
    logic                 hi, guard, sticky, rnd, carry;
    logic [F-1:0]         frac;
    logic [F:0]           frac_r;
    logic signed [XW-1:0] exp_n;

    assign hi     = prod[2*M-1];
    assign frac   = hi ? prod[2*M-2:M] : prod[2*M-3:M-1];
    assign guard  = hi ? prod[M-1] : prod[M-2];
    assign sticky = hi ? (|prod[M-2:0]) : (|prod[M-3:0]);
    assign rnd    = guard & (sticky | frac[0]);
    assign frac_r = {1'b0, frac} + (F+1)'(rnd);
    assign carry  = frac_r[F];
    assign exp_n  = exp_sum + XW'(hi) + XW'(carry);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = CHECK;
            CHECK:   state_next = special ? DONE : MULT;
            MULT:    if (count == CW'(N - 1)) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: capture, classify, multiply, normalise, hold result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r            <= '0;
            b_r            <= '0;
            sign_r         <= 1'b0;
            mant_a         <= '0;
            prod           <= '0;
            exp_sum        <= '0;
            count          <= '0;
            result         <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_r            <= a;
                    b_r            <= b;
                    flag_invalid   <= 1'b0;
                    flag_overflow  <= 1'b0;
                    flag_underflow <= 1'b0;
                    flag_inexact   <= 1'b0;
                end
                CHECK: begin
                    sign_r  <= a_r[W-1] ^ b_r[W-1];
                    mant_a  <= {1'b1, a_r[F-1:0]};
                    prod    <= {{M{1'b0}}, 1'b1, b_r[F-1:0]};
                    count   <= '0;
                    exp_sum <= XW'(ea) + XW'(eb) - XW'(BIAS);
                    if (a_nan || b_nan) begin
                        result       <= QNAN;
                        flag_invalid <= 1'b1;
                    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                        result       <= QNAN;
                        flag_invalid <= 1'b1;
                    end else if (a_inf || b_inf) begin
                        result <= {a_r[W-1] ^ b_r[W-1], {E{1'b1}}, {F{1'b0}}};
                    end else if (a_zero || b_zero) begin
                        result <= {a_r[W-1] ^ b_r[W-1], {(W-1){1'b0}}};
                    end
                end
                MULT: begin
                    prod  <= prod_step;
                    count <= count + 1'b1;
                end
                NORM: begin
                    if (exp_n >= EXP_MAX) begin
                        result        <= {sign_r, {E{1'b1}}, {F{1'b0}}};
                        flag_overflow <= 1'b1;
                        flag_inexact  <= 1'b1;
                    end else if (exp_n <= EXP_MIN) begin
                        result         <= {sign_r, {(W-1){1'b0}}};
                        flag_underflow <= 1'b1;
                        flag_inexact   <= 1'b1;
                    end else begin
                        result       <= {sign_r, exp_n[E-1:0], frac_r[F-1:0]};
                        flag_inexact <= guard | sticky;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
